// File: rtl/rd_deserializer_if.sv
// Link and trace-port signal bundle for the RD serial receiver.
// The master side drives the serial link; the slave side is the deserializer.
interface rd_deserializer_if #(
  parameter int ADDR_WIDTH = 11
);
  logic                  enable_xfr;
  logic                  serial_in0;
  logic                  serial_in1;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_data;
  logic                  xfr_done;
  logic [ADDR_WIDTH:0]   word_count;
  logic [7:0]            perr_count;
  logic                  truncated;
  logic                  overflow;

  modport master (
    output enable_xfr, serial_in0, serial_in1,
    input  wr_en, wr_addr, wr_data, xfr_done, word_count, perr_count, truncated, overflow
  );

  modport slave (
    input  enable_xfr, serial_in0, serial_in1,
    output wr_en, wr_addr, wr_data, xfr_done, word_count, perr_count, truncated, overflow
  );
endinterface

// File: rtl/rd_deserializer.sv
// Receive side of the RD detector link: deserialises two odd-parity channels framed by
// enable_xfr, writes each word pair to the trace BRAM port and keeps transfer status.
module rd_deserializer #(
  parameter int DATA_WIDTH = 12,
  parameter int MEM_SIZE   = 2048,
  parameter int ADDR_WIDTH = 11
) (
  input logic              local_clk,
  input logic              rst_n,
  input logic              srst,
  rd_deserializer_if.slave bus
);
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam int PAD_W = 15 - DATA_WIDTH;
  localparam logic [CNT_W-1:0]    PARITY_IDX = CNT_W'(DATA_WIDTH);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT  = (ADDR_WIDTH + 1)'(MEM_SIZE);

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_nxt_s;
  logic                    start_s;
  logic                    stop_s;
  logic                    perr0_s;
  logic                    perr1_s;
  logic [CNT_W-1:0]        bit_cnt_r;
  logic [DATA_WIDTH-1:0]   sh0_r;
  logic [DATA_WIDTH-1:0]   sh1_r;
  logic                    wr_en_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [31:0]             wr_data_r;
  logic                    xfr_done_r;
  logic [ADDR_WIDTH:0]     word_cnt_r;
  logic [7:0]              perr_cnt_r;
  logic                    trunc_r;
  logic                    ovf_r;

  function automatic logic perr_f(input logic [DATA_WIDTH-1:0] data, input logic par);
    return ~^{data, par};
  endfunction

  // The parity bit arrives live on the link, so the check combines it with the stored data.
  assign perr0_s = perr_f(sh0_r, bus.serial_in0);
  assign perr1_s = perr_f(sh1_r, bus.serial_in1);

  // Transfer state register.
  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else if (srst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and transfer start/stop strobes.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    stop_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.enable_xfr) begin
          state_nxt_s = RECV;
          start_s     = 1'b1;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RECV: begin
        if (!bus.enable_xfr) begin
          state_nxt_s = IDLE;
          stop_s      = 1'b1;
        end else begin
          state_nxt_s = RECV;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Bit shifting, word write-out and status counters.
  always_ff @(posedge local_clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_r  <= '0;
      sh0_r      <= '0;
      sh1_r      <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= 32'd0;
      xfr_done_r <= 1'b0;
      word_cnt_r <= '0;
      perr_cnt_r <= 8'd0;
      trunc_r    <= 1'b0;
      ovf_r      <= 1'b0;
    end else if (srst) begin
      bit_cnt_r  <= '0;
      sh0_r      <= '0;
      sh1_r      <= '0;
      wr_en_r    <= 1'b0;
      wr_addr_r  <= '0;
      wr_data_r  <= 32'd0;
      xfr_done_r <= 1'b0;
      word_cnt_r <= '0;
      perr_cnt_r <= 8'd0;
      trunc_r    <= 1'b0;
      ovf_r      <= 1'b0;
    end else begin
      wr_en_r    <= 1'b0;
      xfr_done_r <= stop_s;
      if (start_s) begin
        word_cnt_r <= '0;
        perr_cnt_r <= 8'd0;
        trunc_r    <= 1'b0;
        ovf_r      <= 1'b0;
      end
      if (bus.enable_xfr) begin
        if (bit_cnt_r == PARITY_IDX) begin
          bit_cnt_r <= '0;
          // Once the trace memory is full further words are counted as overflow only.
          if (word_cnt_r == MEM_LIMIT) begin
            ovf_r <= 1'b1;
          end else begin
            wr_en_r    <= 1'b1;
            wr_addr_r  <= word_cnt_r[ADDR_WIDTH-1:0];
            wr_data_r  <= {{PAD_W{1'b0}}, perr1_s, sh1_r, {PAD_W{1'b0}}, perr0_s, sh0_r};
            word_cnt_r <= word_cnt_r + {{ADDR_WIDTH{1'b0}}, 1'b1};
            if ((perr0_s || perr1_s) && (perr_cnt_r != 8'hFF)) begin
              perr_cnt_r <= perr_cnt_r + 8'd1;
            end
          end
        end else begin
          bit_cnt_r <= bit_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
          sh0_r     <= {sh0_r[DATA_WIDTH-2:0], bus.serial_in0};
          sh1_r     <= {sh1_r[DATA_WIDTH-2:0], bus.serial_in1};
        end
      end else begin
        bit_cnt_r <= '0;
        if (stop_s && (bit_cnt_r != '0)) begin
          trunc_r <= 1'b1;
        end
      end
    end
  end

  assign bus.wr_en      = wr_en_r;
  assign bus.wr_addr    = wr_addr_r;
  assign bus.wr_data    = wr_data_r;
  assign bus.xfr_done   = xfr_done_r;
  assign bus.word_count = word_cnt_r;
  assign bus.perr_count = perr_cnt_r;
  assign bus.truncated  = trunc_r;
  assign bus.overflow   = ovf_r;
endmodule

// File: tb/tb_rd_deserializer.sv
// Bench for rd_deserializer: a full-size and a 4-word instance share one stimulus stream,
// each checked every cycle against a frame-level model plus hand-computed expectations.
module tb_rd_deserializer;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic srst  = 1'b0;
  logic en    = 1'b0;
  logic in0   = 1'b0;
  logic in1   = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int MS = (g == 0) ? 2048 : 4;
    localparam int AW = (g == 0) ? 11 : 2;

    rd_deserializer_if #(.ADDR_WIDTH(AW)) bus ();
    assign bus.enable_xfr = en;
    assign bus.serial_in0 = in0;
    assign bus.serial_in1 = in1;

    rd_deserializer #(.DATA_WIDTH(12), .MEM_SIZE(MS), .ADDR_WIDTH(AW)) dut (
      .local_clk (clk),
      .rst_n     (rst_n),
      .srst      (srst),
      .bus       (bus)
    );

    logic        m_wr_en = 1'b0;
    logic        m_done  = 1'b0;
    logic        m_tr    = 1'b0;
    logic        m_ov    = 1'b0;
    logic [31:0] m_data  = 32'd0;
    logic [12:0] f0      = 13'd0;
    logic [12:0] f1      = 13'd0;
    int          m_addr  = 0;
    int          m_wc    = 0;
    int          m_pc    = 0;
    int          nb      = 0;
    bit          in_xfr  = 1'b0;
    int          n_wr    = 0;
    int          n_done  = 0;
    logic [31:0] wdat [64];
    int          wadr [64];
    int          wcyc [64];

    // Frame-level model: counts consumed bits, and every 13th bit closes a frame.
    initial forever begin
      logic p0, p1;
      @(posedge clk or negedge rst_n);
      if (!rst_n || srst) begin
        m_wr_en = 1'b0; m_done = 1'b0; m_tr = 1'b0; m_ov = 1'b0; m_data = 32'd0;
        m_addr = 0; m_wc = 0; m_pc = 0; nb = 0; in_xfr = 1'b0;
      end else begin
        m_wr_en = 1'b0;
        m_done  = 1'b0;
        if (en) begin
          if (!in_xfr) begin
            in_xfr = 1'b1; nb = 0; m_wc = 0; m_pc = 0; m_tr = 1'b0; m_ov = 1'b0;
          end
          f0 = {f0[11:0], in0};
          f1 = {f1[11:0], in1};
          nb = nb + 1;
          if (nb % 13 == 0) begin
            if (m_wc < MS) begin
              p0 = ($countones(f0) % 2 == 0);
              p1 = ($countones(f1) % 2 == 0);
              m_wr_en = 1'b1;
              m_addr  = m_wc;
              m_data  = {3'b000, p1, f1[12:1], 3'b000, p0, f0[12:1]};
              m_wc    = m_wc + 1;
              if ((p0 || p1) && m_pc < 255) m_pc = m_pc + 1;
            end else begin
              m_ov = 1'b1;
            end
          end
        end else if (in_xfr) begin
          in_xfr = 1'b0;
          m_done = 1'b1;
          if (nb % 13 != 0) m_tr = 1'b1;
        end
      end
    end

    // Per-cycle comparison against the model, plus a log of writes for literal checks.
    initial forever begin
      @(negedge clk);
      check($sformatf("u%0d.wr_en", g), 64'(bus.wr_en), 64'(m_wr_en));
      if (m_wr_en) begin
        check($sformatf("u%0d.wr_addr", g), 64'(bus.wr_addr), 64'(m_addr));
        check($sformatf("u%0d.wr_data", g), 64'(bus.wr_data), 64'(m_data));
      end
      check($sformatf("u%0d.xfr_done", g), 64'(bus.xfr_done), 64'(m_done));
      check($sformatf("u%0d.word_count", g), 64'(bus.word_count), 64'(m_wc));
      check($sformatf("u%0d.perr_count", g), 64'(bus.perr_count), 64'(m_pc));
      check($sformatf("u%0d.truncated", g), 64'(bus.truncated), 64'(m_tr));
      check($sformatf("u%0d.overflow", g), 64'(bus.overflow), 64'(m_ov));
      if (bus.wr_en) begin
        if (n_wr < 64) begin
          wdat[n_wr] = bus.wr_data;
          wadr[n_wr] = int'(bus.wr_addr);
          wcyc[n_wr] = cyc;
        end
        n_wr = n_wr + 1;
      end
      if (bus.xfr_done) n_done = n_done + 1;
    end
  end

  // Drives nbits of one frame per channel, MSB first then odd parity (optionally inverted).
  task automatic drive_bits(input logic [11:0] d0, input logic [11:0] d1,
                            input logic flip0, input logic flip1, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      en = 1'b1;
      if (i < 12) begin
        in0 = d0[11-i];
        in1 = d1[11-i];
      end else begin
        in0 = (~^d0) ^ flip0;
        in1 = (~^d1) ^ flip1;
      end
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      en  = 1'b0;
      in0 = 1'b0;
      in1 = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    int b0, b1, dn0, t0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("reset word_count", 64'(u[0].bus.word_count), 64'd0);
    check("reset wr_data", 64'(u[1].bus.wr_data), 64'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(2);

    // Single word, all-zero / all-ones channels.
    b0 = u[0].n_wr; dn0 = u[0].n_done; t0 = cyc;
    drive_bits(12'h000, 12'hFFF, 1'b0, 1'b0, 13);
    idle(4);
    check("t1 writes", 64'(u[0].n_wr - b0), 64'd1);
    check("t1 wr_addr", 64'(u[0].wadr[b0]), 64'd0);
    check("t1 wr_data", 64'(u[0].wdat[b0]), 64'h0FFF_0000);
    check("t1 wr cycle", 64'(u[0].wcyc[b0] - t0), 64'd13);
    check("t1 done", 64'(u[0].n_done - dn0), 64'd1);
    check("t1 word_count", 64'(u[0].bus.word_count), 64'd1);
    check("t1 perr_count", 64'(u[0].bus.perr_count), 64'd0);

    // Four back-to-back frames.
    b0 = u[0].n_wr; t0 = cyc;
    for (int k = 0; k < 4; k++) drive_bits(12'hABC, 12'(k), 1'b0, 1'b0, 13);
    idle(4);
    check("t2 writes", 64'(u[0].n_wr - b0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("t2 cycle%0d", k), 64'(u[0].wcyc[b0+k] - t0), 64'(13 * (k + 1)));
      check($sformatf("t2 addr%0d", k), 64'(u[0].wadr[b0+k]), 64'(k));
    end
    check("t2 data2", 64'(u[0].wdat[b0+2]), 64'h0002_0ABC);
    check("t2 perr_count", 64'(u[0].bus.perr_count), 64'd0);

    // Channel 1 parity inverted on word 2.
    b0 = u[0].n_wr;
    for (int k = 0; k < 4; k++) drive_bits(12'hABC, 12'(k), 1'b0, (k == 2), 13);
    idle(4);
    check("t3 data1", 64'(u[0].wdat[b0+1]), 64'h0001_0ABC);
    check("t3 data2", 64'(u[0].wdat[b0+2]), 64'h1002_0ABC);
    check("t3 data3", 64'(u[0].wdat[b0+3]), 64'h0003_0ABC);
    check("t3 perr_count", 64'(u[0].bus.perr_count), 64'd1);

    // Enable dropped after 5 bits of word 1.
    b0 = u[0].n_wr; dn0 = u[0].n_done;
    drive_bits(12'h123, 12'h456, 1'b0, 1'b0, 13);
    drive_bits(12'h789, 12'hFED, 1'b0, 1'b0, 5);
    idle(4);
    check("t4 writes", 64'(u[0].n_wr - b0), 64'd1);
    check("t4 truncated", 64'(u[0].bus.truncated), 64'd1);
    check("t4 word_count", 64'(u[0].bus.word_count), 64'd1);
    check("t4 done", 64'(u[0].n_done - dn0), 64'd1);

    // Five frames: the 4-word instance overflows, the full-size one does not.
    b0 = u[0].n_wr; b1 = u[1].n_wr;
    for (int k = 0; k < 5; k++) drive_bits(12'(k + 1), 12'h555, 1'b0, 1'b0, 13);
    idle(4);
    check("t5 small writes", 64'(u[1].n_wr - b1), 64'd4);
    check("t5 small last addr", 64'(u[1].wadr[b1+3]), 64'd3);
    check("t5 small overflow", 64'(u[1].bus.overflow), 64'd1);
    check("t5 small word_count", 64'(u[1].bus.word_count), 64'd4);
    check("t5 big writes", 64'(u[0].n_wr - b0), 64'd5);
    check("t5 big overflow", 64'(u[0].bus.overflow), 64'd0);
    check("t5 status held", 64'(u[1].bus.truncated), 64'd0);

    // Reset at bit 7 of word 3, then a fresh 2-word transfer.
    dn0 = u[0].n_done;
    for (int k = 0; k < 3; k++) drive_bits(12'h3C3, 12'h0F0, 1'b0, 1'b0, 13);
    drive_bits(12'h3C3, 12'h0F0, 1'b0, 1'b0, 7);
    #2 rst_n = 1'b0;
    en = 1'b0; in0 = 1'b0; in1 = 1'b0;
    @(negedge clk);
    check("t6 reset word_count", 64'(u[0].bus.word_count), 64'd0);
    check("t6 reset wr_data", 64'(u[0].bus.wr_data), 64'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    idle(3);
    check("t6 no done", 64'(u[0].n_done - dn0), 64'd0);
    b0 = u[0].n_wr;
    drive_bits(12'hF00, 12'h00F, 1'b0, 1'b0, 13);
    drive_bits(12'h0F0, 12'hF0F, 1'b0, 1'b0, 13);
    idle(4);
    check("t6 addr0", 64'(u[0].wadr[b0]), 64'd0);
    check("t6 addr1", 64'(u[0].wadr[b0+1]), 64'd1);
    check("t6 word_count", 64'(u[0].bus.word_count), 64'd2);

    // Soft reset clears the held status.
    srst = 1'b1;
    @(negedge clk);
    srst = 1'b0;
    @(negedge clk);
    check("srst word_count", 64'(u[0].bus.word_count), 64'd0);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
